fetch_sequencer: RTL and testbench

Instruction fetch/decode/execute control FSM for the 8-bit lab CPU. It is the initiator side of the program counter's LOAD_PC/INCR_PC/ADDR interface and drives the PC, memory-address select, memory write, and accumulator/ALU strobes. It executes a fixed 1- and 2-byte ISA read from asynchronous-read program/data memory.

---
 rtl/fetch_sequencer_if.sv | 25 ++
 rtl/fetch_sequencer.sv | 113 +++++++++++
 tb/tb_fetch_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Control bus between the fetch sequencer (master) and the PC/memory/ALU datapath (slave).
interface fetch_sequencer_if;
   logic       RUN;
   logic [7:0] MEM_DATA;
   logic       ZERO;
   logic       LOAD_PC;
   logic       INCR_PC;
   logic [7:0] ADDR;
   logic       ADDR_SEL;
   logic       MEM_WE;
   logic       LOAD_ACC;
   logic [1:0] ALU_OP;
   logic       HALTED;
   logic [1:0] STATE;

   modport master (
      input  RUN, MEM_DATA, ZERO,
      output LOAD_PC, INCR_PC, ADDR, ADDR_SEL, MEM_WE, LOAD_ACC, ALU_OP, HALTED, STATE
   );

   modport slave (
      output RUN, MEM_DATA, ZERO,
      input  LOAD_PC, INCR_PC, ADDR, ADDR_SEL, MEM_WE, LOAD_ACC, ALU_OP, HALTED, STATE
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute control FSM for the 8-bit lab CPU: 1-byte ops take 2 cycles, 2-byte ops 3.
// Strobes are combinational from state/opcode/ZERO; RUN stalls only in FETCH.
module fetch_sequencer (
   input  logic              clk,
   input  logic              reset,
   fetch_sequencer_if.master bus
);
   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_DECODE = 2'd1,
      S_EXEC   = 2'd2,
      S_HALT   = 2'd3
   } state_t;

   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_JMP = 4'h5;
   localparam logic [3:0] OP_JZ  = 4'h6;
   localparam logic [3:0] OP_HLT = 4'hF;

   state_t     state_q, state_d;
   logic [3:0] op_q, op_d;     // IR[3:0] never affects behaviour, so only the opcode nibble is kept
   logic [7:0] opr_q, opr_d;

   logic       load_pc, incr_pc, addr_sel, mem_we, load_acc, halted;
   logic [1:0] alu_op;
   logic       two_byte;

   assign two_byte = (op_q >= OP_LDA) && (op_q <= OP_JZ);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_FETCH;
         op_q    <= 4'h0;
         opr_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         opr_q   <= opr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      opr_d    = opr_q;
      load_pc  = 1'b0;
      incr_pc  = 1'b0;
      addr_sel = 1'b0;
      mem_we   = 1'b0;
      load_acc = 1'b0;
      alu_op   = 2'b00;
      halted   = 1'b0;

      case (state_q)
         S_FETCH: begin
            if (bus.RUN) begin
               op_d    = bus.MEM_DATA[7:4];
               incr_pc = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (two_byte) begin
               opr_d   = bus.MEM_DATA;
               incr_pc = 1'b1;
               state_d = S_EXEC;
            end else if (op_q == OP_HLT) begin
               state_d = S_HALT;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_EXEC: begin
            state_d = S_FETCH;
            case (op_q)
               OP_LDA: begin addr_sel = 1'b1; load_acc = 1'b1; alu_op = 2'b00; end
               OP_ADD: begin addr_sel = 1'b1; load_acc = 1'b1; alu_op = 2'b01; end
               OP_SUB: begin addr_sel = 1'b1; load_acc = 1'b1; alu_op = 2'b10; end
               OP_STA: begin addr_sel = 1'b1; mem_we = 1'b1; end
               OP_JMP: load_pc = 1'b1;
               OP_JZ:  load_pc = bus.ZERO;
               default: ;
            endcase
         end
         S_HALT: halted = 1'b1;
         default: state_d = S_FETCH;
      endcase

      // Reset kills every strobe in the same cycle, even mid-instruction
      if (!reset) begin
         load_pc  = 1'b0;
         incr_pc  = 1'b0;
         addr_sel = 1'b0;
         mem_we   = 1'b0;
         load_acc = 1'b0;
         alu_op   = 2'b00;
         halted   = 1'b0;
      end
   end

   assign bus.LOAD_PC  = load_pc;
   assign bus.INCR_PC  = incr_pc;
   assign bus.ADDR     = opr_q;
   assign bus.ADDR_SEL = addr_sel;
   assign bus.MEM_WE   = mem_we;
   assign bus.LOAD_ACC = load_acc;
   assign bus.ALU_OP   = alu_op;
   assign bus.HALTED   = halted;
   assign bus.STATE    = state_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed programs for fetch_sequencer with a small PC/ACC/memory environment; per-cycle
// expected outputs are queued by the stimulus and compared by an independent negedge monitor.
module tb_fetch_sequencer;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fetch_sequencer_if bus();
   fetch_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

   logic [7:0] mem [256];
   logic [7:0] pc, acc, st_addr, st_val;
   int         st_cnt;

   assign bus.MEM_DATA = mem[bus.ADDR_SEL ? bus.ADDR : pc];
   assign bus.ZERO     = (acc == 8'h00);

   always @(posedge clk) begin
      if (!reset) begin
         pc <= 8'h00; acc <= 8'h00; st_cnt <= 0; st_addr <= 8'h00; st_val <= 8'h00;
      end else begin
         if (bus.LOAD_PC)      pc <= bus.ADDR;
         else if (bus.INCR_PC) pc <= pc + 8'h01;
         if (bus.MEM_WE) begin st_cnt <= st_cnt + 1; st_addr <= bus.ADDR; st_val <= acc; end
         if (bus.LOAD_ACC)
            case (bus.ALU_OP)
               2'b00:   acc <= bus.MEM_DATA;
               2'b01:   acc <= acc + bus.MEM_DATA;
               2'b10:   acc <= acc - bus.MEM_DATA;
               default: acc <= acc;
            endcase
      end
   end

   typedef struct packed {
      logic [1:0] st;
      logic       lpc, ipc, sel, we, lacc;
      logic [1:0] op;
      logic       halt;
      logic [7:0] addr;
   } obs_t;

   typedef struct { obs_t o; int id; } exp_t;

   exp_t  q[$];
   int    n_chk = 0, n_fail = 0, vec_id = 0;
   string tname = "init";
   exp_t  mx;
   obs_t  mo;

   function automatic obs_t e(int st, bit lpc, bit ipc, bit sel, bit we, bit lacc,
                              int op, bit halt, int addr);
      obs_t o;
      o.st = 2'(st); o.lpc = lpc; o.ipc = ipc; o.sel = sel; o.we = we; o.lacc = lacc;
      o.op = 2'(op); o.halt = halt; o.addr = 8'(addr);
      return o;
   endfunction

   function automatic obs_t fe(int a); return e(0,0,1,0,0,0,0,0,a); endfunction
   function automatic obs_t de(int a); return e(1,0,1,0,0,0,0,0,a); endfunction
   function automatic obs_t dn(int a); return e(1,0,0,0,0,0,0,0,a); endfunction
   function automatic obs_t hl(int a); return e(3,0,0,0,0,0,0,1,a); endfunction
   function automatic obs_t z(int s, int a); return e(s,0,0,0,0,0,0,0,a); endfunction

   task automatic push(obs_t o);
      exp_t x;
      x.o = o; x.id = vec_id; vec_id++;
      q.push_back(x);
   endtask

   task automatic run(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(string name, int got, int want);
      n_chk++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         mx = q.pop_front();
         mo = {bus.STATE, bus.LOAD_PC, bus.INCR_PC, bus.ADDR_SEL, bus.MEM_WE, bus.LOAD_ACC,
               bus.ALU_OP, bus.HALTED, bus.ADDR};
         n_chk++;
         if (mo !== mx.o) begin
            n_fail++;
            $display("FAIL %s vec %0d: got st=%0d lpc=%b ipc=%b sel=%b we=%b lacc=%b op=%b halt=%b addr=%h, want st=%0d lpc=%b ipc=%b sel=%b we=%b lacc=%b op=%b halt=%b addr=%h",
                     tname, mx.id, mo.st, mo.lpc, mo.ipc, mo.sel, mo.we, mo.lacc, mo.op, mo.halt, mo.addr,
                     mx.o.st, mx.o.lpc, mx.o.ipc, mx.o.sel, mx.o.we, mx.o.lacc, mx.o.op, mx.o.halt, mx.o.addr);
         end
      end
   end

   // First reset cycle still shows the previous state/operand; outputs already forced low
   task automatic do_reset(int ps, int pa, int n);
      reset = 1'b0; bus.RUN = 1'b1;
      push(z(ps, pa));
      for (int i = 1; i < n; i++) push(z(0, 0));
      run(n);
      reset = 1'b1;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
   endtask

   initial begin
      reset = 1'b0; bus.RUN = 1'b1;
      clear_mem();
      @(posedge clk); #1;

      tname = "reset_hold";
      for (int i = 0; i < 3; i++) push(z(0, 0));
      run(3);

      tname = "idle_run0";
      reset = 1'b1; bus.RUN = 1'b0;
      for (int i = 0; i < 5; i++) push(z(0, 0));
      run(5);

      // LDA 0x20; ADD 0x21; HLT
      tname = "load_add";
      clear_mem();
      mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h20; mem[3] = 8'h21; mem[4] = 8'hF0;
      mem[8'h20] = 8'd5; mem[8'h21] = 8'd7;
      do_reset(0, 0, 2);
      push(fe(0)); push(de(0)); push(e(2,0,0,1,0,1,0,0,8'h20));
      push(fe(8'h20)); push(de(8'h20)); push(e(2,0,0,1,0,1,1,0,8'h21));
      push(fe(8'h21)); push(dn(8'h21));
      for (int i = 0; i < 4; i++) push(hl(8'h21));
      run(12);
      chk("load_add_acc", int'(acc), 12);
      chk("load_add_pc", int'(pc), 5);

      // LDA 0x20; STA 0x30; HLT
      tname = "store";
      clear_mem();
      mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h40; mem[3] = 8'h30; mem[4] = 8'hF0;
      mem[8'h20] = 8'd5;
      do_reset(3, 8'h21, 2);
      push(fe(0)); push(de(0)); push(e(2,0,0,1,0,1,0,0,8'h20));
      push(fe(8'h20)); push(de(8'h20)); push(e(2,0,0,1,1,0,0,0,8'h30));
      push(fe(8'h30)); push(dn(8'h30)); push(hl(8'h30)); push(hl(8'h30));
      run(10);
      chk("store_count", st_cnt, 1);
      chk("store_addr", int'(st_addr), 8'h30);
      chk("store_data", int'(st_val), 5);

      // LDA 0x80(=3); JMP 0x40; JZ 0x50 (not taken); SUB 0x80; JZ 0x50 (taken); HLT at 0x50
      tname = "branch";
      clear_mem();
      mem[0] = 8'h10; mem[1] = 8'h80; mem[2] = 8'h50; mem[3] = 8'h40;
      mem[8'h40] = 8'h60; mem[8'h41] = 8'h50; mem[8'h42] = 8'h30; mem[8'h43] = 8'h80;
      mem[8'h44] = 8'h60; mem[8'h45] = 8'h50; mem[8'h50] = 8'hF0; mem[8'h80] = 8'd3;
      do_reset(3, 8'h30, 2);
      push(fe(0));     push(de(0));     push(e(2,0,0,1,0,1,0,0,8'h80));
      push(fe(8'h80)); push(de(8'h80)); push(e(2,1,0,0,0,0,0,0,8'h40));
      push(fe(8'h40)); push(de(8'h40)); push(z(2, 8'h50));
      push(fe(8'h50)); push(de(8'h50)); push(e(2,0,0,1,0,1,2,0,8'h80));
      push(fe(8'h80)); push(de(8'h80)); push(e(2,1,0,0,0,0,0,0,8'h50));
      push(fe(8'h50)); push(dn(8'h50)); push(hl(8'h50)); push(hl(8'h50));
      run(19);
      chk("branch_pc", int'(pc), 8'h51);
      chk("branch_acc", int'(acc), 0);

      // Undefined opcode 0x7A as NOP, then HLT held with RUN=1
      tname = "undef_halt";
      clear_mem();
      mem[0] = 8'h7A; mem[1] = 8'hF0;
      do_reset(3, 8'h50, 2);
      push(fe(0)); push(dn(0)); push(fe(0)); push(dn(0));
      for (int i = 0; i < 12; i++) push(hl(0));
      run(16);
      chk("undef_halt_pc", int'(pc), 2);

      // JMP 0x40 aborted by reset in EXECUTE
      tname = "mid_reset";
      clear_mem();
      mem[0] = 8'h50; mem[1] = 8'h40;
      do_reset(3, 0, 2);
      push(fe(0)); push(de(0));
      run(2);
      reset = 1'b0;
      push(z(2, 8'h40)); push(z(0, 0));
      run(2);
      reset = 1'b1;
      push(fe(0));
      run(1);
      reset = 1'b0;

      chk("queue_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
